// File: rtl/booth_pkg.sv
// Shared widths and weight offsets for the Booth multiplier reduction stages.
package booth_pkg;

  localparam int PW     = 32;  // product width, all arithmetic mod 2^PW
  localparam int HALF   = 16;  // split point between low and high CPA stages
  localparam int C0_OFF = 4;   // weight of c0 relative to s0
  localparam int S1_OFF = 12;  // weight of s1 relative to s0
  localparam int C1_OFF = 16;  // weight of c1 relative to s0

  localparam int S0_W = 24;
  localparam int C0_W = 24;
  localparam int S1_W = 23;
  localparam int C1_W = 20;

  typedef logic [PW-1:0] word_t;

  // Shift an already zero-extended vector to its weight; bits above PW-1 fall off.
  function automatic word_t place(input word_t v, input int off);
    return v << off;
  endfunction

endpackage

// File: rtl/booth_final_add_if.sv
// Handshake and data bundle between the compression stages and the final adder.
interface booth_final_add_if;
  import booth_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [S0_W-1:0] s0;
  logic [C0_W-1:0] c0;
  logic [S1_W-1:0] s1;
  logic [C1_W-1:0] c1;
  logic            out_valid;
  logic            out_ready;
  logic [PW-1:0]   product;

  // Producer / consumer side (drives operands, accepts the product)
  modport master (
    output in_valid, s0, c0, s1, c1, out_ready,
    input  in_ready, out_valid, product
  );

  // Adder side
  modport slave (
    input  in_valid, s0, c0, s1, c1, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/add3.sv
// Single-bit full adder cell used to build the carry-save rows.
module add3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/compress42.sv
// PW-bit 4:2 compressor: two rows of full adders. The returned carry vector is
// already shifted left by one, so sum + carry == x0 + x1 + x2 + x3 (mod 2^PW).
module compress42
  import booth_pkg::*;
(
  input  word_t x0,
  input  word_t x1,
  input  word_t x2,
  input  word_t x3,
  output word_t sum,
  output word_t carry
);
  word_t row1_s;
  word_t row1_c;
  word_t row1_c_sh;
  word_t row2_c;

  // Top carry bits of each row carry weight 2^PW and are discarded (mod 2^PW).
  logic unused_top_carries;
  assign unused_top_carries = row1_c[PW-1] ^ row2_c[PW-1];

  assign row1_c_sh = {row1_c[PW-2:0], 1'b0};
  assign carry     = {row2_c[PW-2:0], 1'b0};

  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_bit
      add3 u_row1 (
        .a  (x0[gi]),
        .b  (x1[gi]),
        .c  (x2[gi]),
        .s  (row1_s[gi]),
        .co (row1_c[gi])
      );
      add3 u_row2 (
        .a  (row1_s[gi]),
        .b  (row1_c_sh[gi]),
        .c  (x3[gi]),
        .s  (sum[gi]),
        .co (row2_c[gi])
      );
    end
  endgenerate
endmodule

// File: rtl/booth_final_add.sv
// Final Booth reduction: 4:2 merge of two sum/carry pairs, then a split
// low/high carry-propagate adder. Three register stages with a valid/ready chain.
module booth_final_add
  import booth_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  booth_final_add_if.slave   bus
);
  localparam int HW = PW - HALF;

  // Stage valid bits
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  // Stage 1 data: compressed sum/carry pair
  word_t s_q, s_d, c_q, c_d;
  // Stage 2 data: low half result, its carry-out, upper halves passed through
  logic [HALF-1:0] lo_q, lo_d;
  logic            cy_q, cy_d;
  logic [HW-1:0]   shi_q, shi_d, chi_q, chi_d;
  // Stage 3 data: final product
  word_t prod_q, prod_d;

  logic rdy1, rdy2, rdy3;
  word_t cmp_sum, cmp_carry;
  logic [HALF:0] lo_sum;
  logic [HW-1:0] hi_sum;

  compress42 u_compress (
    .x0    (place(word_t'(bus.s0), 0)),
    .x1    (place(word_t'(bus.c0), C0_OFF)),
    .x2    (place(word_t'(bus.s1), S1_OFF)),
    .x3    (place(word_t'(bus.c1), C1_OFF)),
    .sum   (cmp_sum),
    .carry (cmp_carry)
  );

  // Ready chain, next-state valids and load-enabled data for all three stages
  always_comb begin
    rdy3 = !v3_q || bus.out_ready;
    rdy2 = !v2_q || rdy3;
    rdy1 = !v1_q || rdy2;

    v1_d = rdy1 ? bus.in_valid : v1_q;
    v2_d = rdy2 ? v1_q : v2_q;
    v3_d = rdy3 ? v2_q : v3_q;

    lo_sum = {1'b0, s_q[HALF-1:0]} + {1'b0, c_q[HALF-1:0]};
    hi_sum = shi_q + chi_q + {{(HW-1){1'b0}}, cy_q};

    s_d    = s_q;
    c_d    = c_q;
    lo_d   = lo_q;
    cy_d   = cy_q;
    shi_d  = shi_q;
    chi_d  = chi_q;
    prod_d = prod_q;

    // Data only moves when a valid item actually enters a stage; otherwise hold.
    if (rdy1 && bus.in_valid) begin
      s_d = cmp_sum;
      c_d = cmp_carry;
    end
    if (rdy2 && v1_q) begin
      lo_d  = lo_sum[HALF-1:0];
      cy_d  = lo_sum[HALF];
      shi_d = s_q[PW-1:HALF];
      chi_d = c_q[PW-1:HALF];
    end
    if (rdy3 && v2_q) begin
      prod_d = {hi_sum, lo_q};
    end
  end

  // Valid bits and the visible product are cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      prod_q <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      prod_q <= prod_d;
    end
  end

  // Internal data registers need no reset: they are qualified by the valid bits
  always_ff @(posedge clk) begin
    s_q   <= s_d;
    c_q   <= c_d;
    lo_q  <= lo_d;
    cy_q  <= cy_d;
    shi_q <= shi_d;
    chi_q <= chi_d;
  end

  assign bus.in_ready  = rdy1;
  assign bus.out_valid = v3_q;
  assign bus.product   = prod_q;
endmodule
